inst_fetch_unit: RTL



---
 rtl/inst_fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Reader side of the instruction memory. Owns the program
//               counter, presents it as the memory address, samples the
//               combinational read data and buffers {pc, word} pairs in a
//               small prefetch FIFO that feeds decode over valid/ready.
//               Branch/jump redirects from execute flush the FIFO and reload
//               the PC.
// Ports       :
//   clk            in   system clock, all state updates on posedge
//   rst_n          in   asynchronous active-low reset
//   fetch_en       in   allow new fetches; low freezes PC and pushes
//   imem_addr      out  [AW]   instruction memory address (= PC register)
//   imem_dout      in   [DW]   memory read data, valid same cycle as address
//   redirect_valid in   one-cycle flush-and-jump request
//   redirect_pc    in   [AW]   jump target
//   inst_valid     out  FIFO head holds a valid instruction
//   inst_ready     in   decode accepts the head this cycle
//   inst_data      out  [DW]   instruction word at FIFO head
//   inst_pc        out  [AW]   fetch address of the head word
//   fifo_level     out  [$clog2(DEPTH)+1]  current FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int             AW       = 8,
    parameter int             DW       = 24,
    parameter int             DEPTH    = 2,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_en,
    output logic [AW-1:0]              imem_addr,
    input  logic [DW-1:0]              imem_dout,
    input  logic                       redirect_valid,
    input  logic [AW-1:0]              redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [DW-1:0]              inst_data,
    output logic [AW-1:0]              inst_pc,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = AW + DW;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ENT_W-1:0]    fifo_q [DEPTH];
    logic [ENT_W-1:0]    fifo_d [DEPTH];

    logic                push;
    logic                pop;
    logic [ENT_W-1:0]    head;

    // Handshake qualifiers. A redirect suppresses both sides so that the
    // flushed head is neither consumed nor replaced on the redirect edge.
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    // A full FIFO can still accept a word when the head leaves this cycle.
    assign push       = fetch_en && !redirect_valid &&
                        ((count_q < CNT_W'(DEPTH)) || pop);

    // Outputs come only from registered storage; imem_dout never reaches
    // inst_data combinationally.
    assign head       = fifo_q[rd_ptr_q];
    assign inst_pc    = head[ENT_W-1:DW];
    assign inst_data  = head[DW-1:0];
    assign imem_addr  = pc_q;
    assign fifo_level = count_q;

    // FLUSH only makes the redirect cycle a visible bubble; fetching
    // proceeds normally from the new PC while in it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   state_d = redirect_valid ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = redirect_valid ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fifo_d   = fifo_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = {pc_q, imem_dout};
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                // Natural wrap at 2**AW, no stall at the top of memory.
                pc_d             = pc_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule
`default_nettype wire
